configurable_cache: RTL and testbench
=====================================

// Module: configurable_cache
// PURPOSE
// - Behavioural/synthesizable m-way set-associative cache tag model for hit-ratio studies.
// - Looks up one 32-bit byte address every clock and reports hit/miss; no data storage.
// - Sits under a trace-driven bench that reads hit/miss per access and the running totals.
// - Exports derived geometry (num_sets, tag_bits) for reporting.
// PARAMETERS
// - CACHE_SIZE     8192  total capacity in bytes; power of two
// - LINE_SIZE      32    bytes per line; power of two, >=1
// - ASSOCIATIVITY  16    ways per set; power of two, 1..CACHE_SIZE/LINE_SIZE
// - Derived (localparam):
//   - NUM_SETS = CACHE_SIZE/(LINE_SIZE*ASSOCIATIVITY)
//   - OFF_W = clog2(LINE_SIZE)
//   - IDX_W = clog2(NUM_SETS), which may be 0
//   - TAG_W = 32-IDX_W-OFF_W
// PORTS
// - clk           in   1   clock, rising edge
// - rst           in   1   reset, synchronous, active-low
// - addr          in   32  byte address of the access for this cycle
// - hit           out  1   registered: last sampled access hit
// - miss          out  1   registered: last sampled access missed
// - total_hits    out  32  running hit count
// - total_misses  out  32  running miss count
// - num_sets      out  32  constant NUM_SETS
// - tag_bits      out  32  constant TAG_W
// BEHAVIOUR
// - Address split:
//   - offset = addr[OFF_W-1:0], ignored
//   - index = addr[OFF_W+IDX_W-1:OFF_W]
//   - tag = addr[31:OFF_W+IDX_W]
// - If IDX_W==0, design is fully associative; all accesses use set 0.
// - Reset (rst==0 at posedge):
//   - All valid bits cleared; replacement state cleared.
//   - hit=0, miss=0, total_hits=0, total_misses=0.
//   - Reset mid-run discards all contents.
// - Every posedge with rst==1 is one access; there is no valid/enable handshake.
// - Latency 1: hit/miss reflect the addr sampled at that edge. Exactly one of hit/miss is 1 every cycle after reset.
// - On hit:
//   - hit<=1, total_hits+=1
//   - Matching way marked most-recently-used.
// - On miss:
//   - miss<=1, total_misses+=1
//   - Victim is the lowest-numbered invalid way if any; otherwise chosen by replacement policy.
//   - Victim gets tag and valid=1 and becomes MRU.
// - Lookup and fill complete in the same edge, so an access to the same line on the next cycle hits.
// - Counters wrap modulo 2^32.
// - num_sets and tag_bits are constant and valid regardless of reset.
// CONFIGURATION
// - CACHE_LRU_EN defined: true LRU per set, with a per-way age counter of clog2(ASSOCIATIVITY) bits.
//   - Evicts the least-recently-used way.
// - CACHE_LRU_EN undefined: FIFO replacement.
//   - Per-set round-robin pointer advanced only on a fill into a full set.
//   - Hits do not change replacement state.
// TESTING (defaults: 16 sets, OFF_W=5, IDX_W=4, TAG_W=23)
// - After reset: num_sets=16, tag_bits=23, hit=miss=0, totals 0.
// - Access 0x0 -> miss; 0x1F -> hit; 0x20 -> miss (set 1).
//   - Result: total_hits=1, total_misses=2.
// - Same-set conflicts, stride 0x200, set 0:
//   - 0x0, 0x200, ... 0x1E00 (16 lines) -> 16 misses.
//   - Access 0x0 again -> hit.
//   - Access 0x2000 -> miss.
//   - Access 0x200 -> miss under LRU (evicted). Without CACHE_LRU_EN, 0x200 hits (0x0 was evicted).
// - Reset asserted mid-stream, then access 0x0 -> miss; totals restart at 0/1.
// - ASSOCIATIVITY=1, stride 0x2000 ping-pong 0x0/0x2000 x4 -> 8 misses, 0 hits.
// - Streaming 1000 sequential word addresses (0,4,8,...):
//   - misses = 125 (one per 32-byte line), hits = 875.
//   - hit+miss equals number of active cycles.

Source files
------------

// File: rtl/configurable_cache.sv
// Set-associative cache tag model: one lookup per clock, registered hit/miss and running totals.
// Replacement is true LRU when CACHE_LRU_EN is defined, otherwise per-set FIFO.
module configurable_cache #(
  parameter int unsigned CACHE_SIZE    = 8192,
  parameter int unsigned LINE_SIZE     = 32,
  parameter int unsigned ASSOCIATIVITY = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic        hit,
  output logic        miss,
  output logic [31:0] total_hits,
  output logic [31:0] total_misses,
  output logic [31:0] num_sets,
  output logic [31:0] tag_bits
);

  localparam int unsigned NUM_SETS = CACHE_SIZE / (LINE_SIZE * ASSOCIATIVITY);
  localparam int unsigned OFF_W    = $clog2(LINE_SIZE);
  localparam int unsigned IDX_W    = $clog2(NUM_SETS);
  localparam int unsigned TAG_W    = 32 - IDX_W - OFF_W;
  localparam int unsigned SET_W    = (IDX_W > 0) ? IDX_W : 1;
  localparam int unsigned WAY_W    = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;

  assign num_sets = 32'(NUM_SETS);
  assign tag_bits = 32'(TAG_W);

  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] addr_tag;

  assign addr_tag = addr[31:OFF_W+IDX_W];

  generate
    if (IDX_W > 0) begin : g_indexed
      assign set_idx = addr[OFF_W+IDX_W-1:OFF_W];
    end else begin : g_fully_assoc
      assign set_idx = '0;
    end
    if (OFF_W > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^addr[OFF_W-1:0];
    end
  endgenerate

  logic             valid_q [NUM_SETS][ASSOCIATIVITY];
  logic             valid_d [NUM_SETS][ASSOCIATIVITY];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][ASSOCIATIVITY];
  logic [TAG_W-1:0] tag_d   [NUM_SETS][ASSOCIATIVITY];
`ifdef CACHE_LRU_EN
  logic [WAY_W-1:0] age_q   [NUM_SETS][ASSOCIATIVITY];
  logic [WAY_W-1:0] age_d   [NUM_SETS][ASSOCIATIVITY];
  logic [WAY_W-1:0] ref_age;
`else
  logic [WAY_W-1:0] ptr_q   [NUM_SETS];
  logic [WAY_W-1:0] ptr_d   [NUM_SETS];
`endif

  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [31:0] total_hits_q, total_hits_d;
  logic [31:0] total_misses_q, total_misses_d;

  logic             lookup_hit;
  logic             has_inv;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] repl_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] touch_way;

  // Tag match and lowest-numbered invalid way in the addressed set.
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    has_inv    = 1'b0;
    inv_way    = '0;
    for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == addr_tag) && !lookup_hit) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
      if (!valid_q[set_idx][w] && !has_inv) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    repl_way = '0;
`ifdef CACHE_LRU_EN
    for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
      if (age_q[set_idx][w] == WAY_W'(ASSOCIATIVITY - 1)) begin
        repl_way = WAY_W'(w);
      end
    end
`else
    repl_way = ptr_q[set_idx];
`endif
  end

  assign victim_way = has_inv ? inv_way : repl_way;
  assign touch_way  = lookup_hit ? hit_way : victim_way;

  always_comb begin
    valid_d        = valid_q;
    tag_d          = tag_q;
    hit_d          = lookup_hit;
    miss_d         = !lookup_hit;
    total_hits_d   = total_hits_q;
    total_misses_d = total_misses_q;

    if (lookup_hit) begin
      total_hits_d = total_hits_q + 32'd1;
    end else begin
      total_misses_d                 = total_misses_q + 32'd1;
      valid_d[set_idx][victim_way]   = 1'b1;
      tag_d[set_idx][victim_way]     = addr_tag;
    end
  end

`ifdef CACHE_LRU_EN
  // Valid ways hold distinct ages 0..k-1; a fill into an invalid way acts as
  // touching the oldest slot so every valid way ages by one.
  always_comb begin
    age_d   = age_q;
    ref_age = valid_q[set_idx][touch_way] ? age_q[set_idx][touch_way]
                                          : WAY_W'(ASSOCIATIVITY - 1);
    for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
      if (WAY_W'(w) == touch_way) begin
        age_d[set_idx][w] = '0;
      end else if (valid_q[set_idx][w] && (age_q[set_idx][w] < ref_age)) begin
        age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (!lookup_hit && !has_inv) begin
      ptr_d[set_idx] = (ptr_q[set_idx] == WAY_W'(ASSOCIATIVITY - 1)) ? '0
                                                                     : ptr_q[set_idx] + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
          valid_q[s][w] <= 1'b0;
`ifdef CACHE_LRU_EN
          age_q[s][w]   <= '0;
`endif
        end
`ifndef CACHE_LRU_EN
        ptr_q[s] <= '0;
`endif
      end
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      total_hits_q   <= '0;
      total_misses_q <= '0;
    end else begin
      valid_q        <= valid_d;
`ifdef CACHE_LRU_EN
      age_q          <= age_d;
`else
      ptr_q          <= ptr_d;
`endif
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      total_hits_q   <= total_hits_d;
      total_misses_q <= total_misses_d;
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= tag_d;
    end
  end

  assign hit          = hit_q;
  assign miss         = miss_q;
  assign total_hits   = total_hits_q;
  assign total_misses = total_misses_q;

endmodule

// File: tb/tb_configurable_cache.sv
// Scoreboard bench for configurable_cache: a 16-way default instance and a direct-mapped instance.
module tb_configurable_cache;

`ifdef CACHE_LRU_EN
  localparam bit LRU = 1'b1;
`else
  localparam bit LRU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2;
  logic [31:0] addr, addr2;
  logic        hit, miss, hit2, miss2;
  logic [31:0] total_hits, total_misses, num_sets, tag_bits;
  logic [31:0] total_hits2, total_misses2, num_sets2, tag_bits2;

  configurable_cache #(.CACHE_SIZE(8192), .LINE_SIZE(32), .ASSOCIATIVITY(16)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .hit(hit), .miss(miss),
    .total_hits(total_hits), .total_misses(total_misses),
    .num_sets(num_sets), .tag_bits(tag_bits)
  );

  configurable_cache #(.CACHE_SIZE(8192), .LINE_SIZE(32), .ASSOCIATIVITY(1)) u_dm (
    .clk(clk), .rst(rst2), .addr(addr2), .hit(hit2), .miss(miss2),
    .total_hits(total_hits2), .total_misses(total_misses2),
    .num_sets(num_sets2), .tag_bits(tag_bits2)
  );

  typedef struct packed {
    logic        h;
    logic        m;
    logic [31:0] th;
    logic [31:0] tm;
  } exp_t;

  exp_t  q1[$], q2[$];
  string n1[$], n2[$];
  exp_t  e1, e2;
  string s1, s2;

  int          checks = 0;
  int          errors = 0;
  int unsigned eh = 0, em = 0, eh2 = 0, em2 = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic acc(input logic [31:0] a, input logic exp_hit, input string nm);
    @(negedge clk);
    rst  = 1'b1;
    addr = a;
    if (exp_hit) eh++; else em++;
    q1.push_back({exp_hit, !exp_hit, 32'(eh), 32'(em)});
    n1.push_back(nm);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      eh  = 0;
      em  = 0;
      q1.push_back({1'b0, 1'b0, 32'd0, 32'd0});
      n1.push_back("reset");
    end
  endtask

  task automatic acc2(input logic [31:0] a, input logic exp_hit, input string nm);
    @(negedge clk);
    rst2  = 1'b1;
    addr2 = a;
    if (exp_hit) eh2++; else em2++;
    q2.push_back({exp_hit, !exp_hit, 32'(eh2), 32'(em2)});
    n2.push_back(nm);
  endtask

  task automatic do_reset2();
    @(negedge clk);
    rst2 = 1'b0;
    eh2  = 0;
    em2  = 0;
    q2.push_back({1'b0, 1'b0, 32'd0, 32'd0});
    n2.push_back("dm_reset");
  endtask

  always @(posedge clk) begin
    #1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      s1 = n1.pop_front();
      checks++;
      if ({hit, miss, total_hits, total_misses} !== e1) begin
        errors++;
        $display("FAIL %s: got hit=%b miss=%b hits=%0d misses=%0d want hit=%b miss=%b hits=%0d misses=%0d",
                 s1, hit, miss, total_hits, total_misses, e1.h, e1.m, e1.th, e1.tm);
      end
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      s2 = n2.pop_front();
      checks++;
      if ({hit2, miss2, total_hits2, total_misses2} !== e2) begin
        errors++;
        $display("FAIL %s: got hit=%b miss=%b hits=%0d misses=%0d want hit=%b miss=%b hits=%0d misses=%0d",
                 s2, hit2, miss2, total_hits2, total_misses2, e2.h, e2.m, e2.th, e2.tm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    rst2  = 1'b0;
    addr  = '0;
    addr2 = '0;
    #2;
    chk("num_sets", num_sets, 32'd16);
    chk("tag_bits", tag_bits, 32'd23);
    chk("dm_num_sets", num_sets2, 32'd256);
    chk("dm_tag_bits", tag_bits2, 32'd19);

    do_reset(2);

    acc(32'h0000_0000, 1'b0, "basic_0x0");
    acc(32'h0000_001F, 1'b1, "basic_0x1f");
    acc(32'h0000_0020, 1'b0, "basic_0x20");

    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      acc(32'(i * 32'h200), 1'b0, $sformatf("conflict_fill_%0d", i));
    end
    acc(32'h0000_0000, 1'b1, "conflict_rehit_0x0");
    acc(32'h0000_2000, 1'b0, "conflict_0x2000");
    acc(32'h0000_0200, !LRU, "conflict_0x200");
    acc(32'h0000_0000, LRU, "conflict_again_0x0");

    acc(32'h0000_0000, 1'b1, "pre_reset_0x0");
    do_reset(1);
    acc(32'h0000_0000, 1'b0, "post_reset_0x0");

    do_reset(1);
    for (int i = 0; i < 1000; i++) begin
      acc(32'(i * 4), (i % 8) != 0, $sformatf("stream_%0d", i));
    end
    @(posedge clk);
    #2;
    chk("stream_hits", total_hits, 32'd875);
    chk("stream_misses", total_misses, 32'd125);
    chk("stream_sum", total_hits + total_misses, 32'd1000);

    do_reset2();
    for (int i = 0; i < 4; i++) begin
      acc2(32'h0000_0000, 1'b0, $sformatf("dm_ping_%0d", i));
      acc2(32'h0000_2000, 1'b0, $sformatf("dm_pong_%0d", i));
    end
    @(posedge clk);
    #2;
    chk("dm_hits", total_hits2, 32'd0);
    chk("dm_misses", total_misses2, 32'd8);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
